rca: RTL and testbench
======================

# rca

Parameterised ripple-carry adder: a linear chain of full-adder cells that sums two operands and a carry-in, producing a sum and carry-out. Default width is 32 bits. The combinational result is the primary output. A registered copy of the result, including a signed-overflow flag, is provided so the block can sit directly on a pipeline stage boundary in the datapath.

## Interface
- WIDTH, 32, operand/sum width in bits (≥1)
- clk  input  1  rising-edge clock for the output register stage
- rst_n  input  1  reset; one clock; asynchronous, active-low
- a  input  WIDTH  operand A, unsigned or two's complement
- b  input  WIDTH  operand B, unsigned or two's complement
- cin  input  1  carry into bit 0
- sum  output  WIDTH  combinational sum, (a + b + cin) mod 2^WIDTH
- cout  output  1  combinational carry out of bit WIDTH-1
- ovf  output  1  combinational signed overflow
- sum_q  output  WIDTH  registered sum
- cout_q  output  1  registered cout
- ovf_q  output  1  registered ovf

## Operation
- Built as WIDTH full-adder cells, chained via a generate loop.
- Cell i inputs: a[i], b[i], c[i]. Cell i outputs: s[i] = a[i]^b[i]^c[i] and c[i+1] = a[i]&b[i] | c[i]&(a[i]^b[i]).
- Chain ends: c[0] = cin, cout = c[WIDTH].
- Result: {cout, sum} = a + b + cin, exact in WIDTH+1 bits. No saturation.
- ovf = c[WIDTH] ^ c[WIDTH-1]. This is true when both operands have the same sign and the sum's sign differs.
- No lookahead or carry-select logic. Carry ripples strictly bit to bit.
- No enable input. The register stage loads every cycle.

## Timing
- sum, cout, ovf: purely combinational from a, b, cin.
  - No clock dependence.
  - Valid after the ripple delay, worst case WIDTH cell delays, e.g. all-ones + cin=1.
  - Environment must hold inputs stable for ≥ one full ripple delay before sampling.
- sum_q, cout_q, ovf_q: capture sum, cout, ovf on each rising clk edge. Latency is 1 cycle.
- Reset:
  - rst_n low immediately forces sum_q=0, cout_q=0, ovf_q=0, regardless of clk.
  - Combinational outputs are unaffected by reset.
  - First capture occurs on the first rising edge after rst_n deasserts.
  - Reset asserted mid-operation discards the pending registered result.
- Input change and clk edge in the same instant: the register captures the value settled before the edge (standard setup). Input changes do not glitch the registered outputs.
- Timing budget: full combinational ripple path must close within one clk period.

## Test plan
- No clock, cin=0, a=0x00000005, b=0x00000002, settle 20 ns -> sum=0x00000007, cout=0, ovf=0.
- cin=0, a=0x0000000F, b=0x0000FFFF -> sum=0x0001000E, cout=0.
- cin=1:
  - a=0x00000008, b=0x00000005 -> sum=0x0000000E, cout=0.
  - a=0x10000FFF, b=0x0000FFFF -> sum=0x10010FFF, cout=0.
- Full-length ripple and overflow:
  - a=0xFFFFFFFF, b=0, cin=1 -> sum=0x00000000, cout=1, ovf=0.
  - a=0x7FFFFFFF, b=0x00000001, cin=0 -> sum=0x80000000, cout=0, ovf=1.
- Clocked:
  - Hold rst_n=0 -> sum_q=0, cout_q=0, ovf_q=0, even while inputs toggle.
  - Release rst_n, apply a=0x80000000, b=0x80000000, cin=0 -> after one rising edge, sum_q=0, cout_q=1, ovf_q=1.
  - Assert rst_n low between edges -> registered outputs clear at once, without waiting for an edge.

Source files
------------

// File: rtl/rca.sv
// Ripple-carry adder: WIDTH chained full-adder cells with a combinational result
// and a registered copy (sum, carry-out, signed overflow) for pipeline boundaries.
module rca #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic [WIDTH-1:0] sum_q,
  output logic             cout_q,
  output logic             ovf_q
);

  logic [WIDTH:0]   w_c;
  logic [WIDTH-1:0] w_s;
  logic [WIDTH-1:0] r_sum_q;
  logic             r_cout_q;
  logic             r_ovf_q;

  assign w_c[0] = cin;

  // Strict bit-to-bit ripple; no lookahead so the chain maps to plain FA cells.
  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    logic w_p;
    assign w_p      = a[i] ^ b[i];
    assign w_s[i]   = w_p ^ w_c[i];
    assign w_c[i+1] = (a[i] & b[i]) | (w_c[i] & w_p);
  end

  assign sum  = w_s;
  assign cout = w_c[WIDTH];
  assign ovf  = w_c[WIDTH] ^ w_c[WIDTH-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sum_q  <= '0;
      r_cout_q <= 1'b0;
      r_ovf_q  <= 1'b0;
    end else begin
      r_sum_q  <= w_s;
      r_cout_q <= w_c[WIDTH];
      r_ovf_q  <= w_c[WIDTH] ^ w_c[WIDTH-1];
    end
  end

  assign sum_q  = r_sum_q;
  assign cout_q = r_cout_q;
  assign ovf_q  = r_ovf_q;

endmodule

// File: tb/tb_rca.sv
// Self-checking bench for rca: directed vectors plus random operands compared
// against an arithmetic model of a + b + cin with sign-rule overflow.
module tb_rca;

  localparam int W = 32;

  logic         clk;
  logic         clk_en;
  logic         rst_n;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;
  logic [W-1:0] sum_q;
  logic         cout_q;
  logic         ovf_q;

  int n_cmp;
  int n_err;

  rca #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .a      (a),
    .b      (b),
    .cin    (cin),
    .sum    (sum),
    .cout   (cout),
    .ovf    (ovf),
    .sum_q  (sum_q),
    .cout_q (cout_q),
    .ovf_q  (ovf_q)
  );

  initial clk = 1'b0;
  always begin
    #5;
    if (clk_en) clk = ~clk;
  end

  // {ovf, cout, sum} from plain integer addition and the operand-sign rule.
  function automatic logic [W+1:0] ref_add(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic ci);
    logic [W:0] t;
    logic       v;
    t = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
    v = (x[W-1] == y[W-1]) && (t[W-1] != x[W-1]);
    return {v, t};
  endfunction

  task automatic chk_comb(input string tag, input logic [W+1:0] exp);
    n_cmp++;
    assert ({ovf, cout, sum} === exp)
    else begin
      n_err++;
      $error("FAIL %s: got ovf/cout/sum=%b/%b/%h want %b/%b/%h", tag, ovf, cout, sum,
             exp[W+1], exp[W], exp[W-1:0]);
    end
  endtask

  task automatic chk_reg(input string tag, input logic [W+1:0] exp);
    n_cmp++;
    assert ({ovf_q, cout_q, sum_q} === exp)
    else begin
      n_err++;
      $error("FAIL %s: got ovf_q/cout_q/sum_q=%b/%b/%h want %b/%b/%h", tag, ovf_q, cout_q,
             sum_q, exp[W+1], exp[W], exp[W-1:0]);
    end
  endtask

  task automatic apply(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci);
    a = x;
    b = y;
    cin = ci;
  endtask

  initial begin
    logic [W+1:0] exp_q;
    n_cmp  = 0;
    n_err  = 0;
    clk_en = 1'b0;
    rst_n  = 1'b0;
    apply('0, '0, 1'b0);

    // Combinational path, clock stopped, reset held (must not affect it).
    apply(32'h0000_0005, 32'h0000_0002, 1'b0); #20;
    chk_comb("add_5_2", {1'b0, 1'b0, 32'h0000_0007});
    apply(32'h0000_000F, 32'h0000_FFFF, 1'b0); #20;
    chk_comb("add_f_ffff", {1'b0, 1'b0, 32'h0001_000E});
    apply(32'h0000_0008, 32'h0000_0005, 1'b1); #20;
    chk_comb("add_8_5_c", {1'b0, 1'b0, 32'h0000_000E});
    apply(32'h1000_0FFF, 32'h0000_FFFF, 1'b1); #20;
    chk_comb("add_mixed_c", {1'b0, 1'b0, 32'h1001_0FFF});
    apply(32'hFFFF_FFFF, 32'h0000_0000, 1'b1); #20;
    chk_comb("full_ripple", {1'b0, 1'b1, 32'h0000_0000});
    apply(32'h7FFF_FFFF, 32'h0000_0001, 1'b0); #20;
    chk_comb("pos_ovf", {1'b1, 1'b0, 32'h8000_0000});
    apply(32'h8000_0000, 32'hFFFF_FFFF, 1'b0); #20;
    chk_comb("neg_ovf", ref_add(32'h8000_0000, 32'hFFFF_FFFF, 1'b0));
    apply(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1); #20;
    chk_comb("all_ones_c", ref_add(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1));
    chk_reg("q_reset_idle", '0);

    for (int i = 0; i < 40; i++) begin
      apply($urandom, $urandom, 1'($urandom_range(0, 1))); #20;
      chk_comb($sformatf("rand_comb_%0d", i), ref_add(a, b, cin));
    end

    // Clock running with reset held: registered outputs stay clear.
    clk_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      apply($urandom, $urandom, 1'($urandom_range(0, 1)));
      @(posedge clk); #1;
      chk_reg($sformatf("q_in_reset_%0d", i), '0);
    end

    @(negedge clk);
    rst_n = 1'b1;
    apply(32'h8000_0000, 32'h8000_0000, 1'b0);
    @(posedge clk); #1;
    chk_reg("q_first_capture", {1'b1, 1'b1, 32'h0000_0000});

    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      apply($urandom, $urandom, 1'($urandom_range(0, 1)));
      exp_q = ref_add(a, b, cin);
      @(posedge clk); #1;
      chk_reg($sformatf("rand_q_%0d", i), exp_q);
    end

    // Mid-operation async reset clears immediately, between edges.
    @(negedge clk);
    apply(32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b1);
    @(posedge clk); #1;
    chk_reg("q_before_rst", {1'b1, 1'b0, 32'hFFFF_FFFF});
    #2;
    rst_n = 1'b0;
    #1;
    chk_reg("q_async_clear", '0);
    chk_comb("comb_in_rst", {1'b1, 1'b0, 32'hFFFF_FFFF});
    @(negedge clk);
    rst_n = 1'b1;
    apply(32'h0000_1234, 32'h0000_0001, 1'b0);
    @(posedge clk); #1;
    chk_reg("q_after_rst", {1'b0, 1'b0, 32'h0000_1235});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
